t08_fetch: RTL and testbench
============================

// Module: t08_fetch
//
// PURPOSE
//   Program-counter / fetch-address generator for the team-08 RISC-V style core.
//   Holds the current instruction address and advances it once per clock.
//   Normal advance is +4 bytes. On a branch or jump the advance is a signed
//   PC-relative offset instead.
//   On a jump it also latches the link (return) address for the register file.
//
// PARAMETERS
//   RESET_PC   32'h0000_0000   program_counter value while reset is asserted
//   PC_STEP    32'd4           sequential increment in bytes
//
// PORTS
//   clk              in   1   system clock; all state updates on rising edge
//   nrst             in   1   reset, asynchronous, ACTIVE-HIGH (1 = reset); name kept per codebase
//   jump             in   1   unconditional PC-relative jump this cycle (JAL-type)
//   branch           in   1   taken conditional branch this cycle (decided upstream)
//   imm_address      in   32  signed byte offset, two's complement, added to current PC
//   ret_address      out  32  link address captured on the last jump (PC of jump + PC_STEP)
//   program_counter  out  32  current instruction fetch address (registered)
//
// BEHAVIOUR
//   - Reset: while nrst==1, asynchronously force program_counter=RESET_PC and
//     ret_address=0. Asserting reset mid-operation takes effect immediately,
//     without waiting for a clock edge.
//   - Reset release: first rising edge after nrst falls performs a normal update.
//   - Each rising edge with nrst==0, next-state selection (priority order):
//       jump==1            : pc <= pc + imm_address;  ret_address <= pc + PC_STEP
//       branch==1          : pc <= pc + imm_address;  ret_address holds
//       otherwise          : pc <= pc + PC_STEP;      ret_address holds
//   - jump and branch both 1: treated as jump (ret_address updated). There is a
//     single target adder, so the target is the same either way.
//   - Addition: 32-bit, imm_address sign-extended by definition (already 32b);
//     result wraps modulo 2^32, with no overflow flag.
//     Example: pc=0x0000_0002, imm=-10 -> 0xFFFF_FFF8.
//   - No alignment check or masking: odd or non-multiple-of-4 offsets are applied
//     verbatim.
//   - Latency: the new PC is visible on program_counter one cycle after the
//     control inputs are sampled. ret_address changes on the same edge as the
//     jump PC update.
//   - Inputs are level-sampled each edge. A jump held high for N cycles applies
//     the offset N times and rewrites ret_address each time.
//   - No handshake or stall input: the PC advances every cycle while out of reset.
//   - Both outputs come directly from flops. There is no combinational path
//     from inputs to outputs.
//
// TESTING
//   1. Reset: pulse nrst=1 for 1 cycle -> program_counter=0, ret_address=0,
//      including an assertion between edges.
//   2. Sequential: jump=branch=0 for 5 edges from 0 -> PC 4,8,12,16,20;
//      ret_address stays 0.
//   3. Branch: PC=20, branch=1, imm=10, one edge -> PC=30, ret_address=0;
//      next idle edge -> PC=34.
//   4. Jump: PC=34, jump=1, imm=10, one edge -> PC=44, ret_address=38;
//      then idle -> PC=48, ret holds 38.
//   5. Jump held / negative offset: PC=48, jump=1, imm=5 for 2 edges -> PC=53
//      (ret=52) then 58 (ret=57). Then imm=-10 -> PC=48 (ret=62).
//      From PC=2 with imm=-10 -> PC=0xFFFF_FFF8 (wrap).
//   6. Simultaneous jump=branch=1, PC=100, imm=-4 -> PC=96, ret_address=104.
//      Then async reset mid-cycle -> both outputs 0 at once.

Source files
------------

// File: rtl/t08_fetch.sv
// rtl/t08_fetch.sv - program counter / fetch address generator with jump link capture
module t08_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        jump,
    input  logic        branch,
    input  logic [31:0] imm_address,
    output logic [31:0] ret_address,
    output logic [31:0] program_counter
);

    logic [31:0] target_pc;
    logic [31:0] seq_pc;

    // One shared target adder serves both jump and branch; sums wrap modulo 2^32.
    assign target_pc = program_counter + imm_address;
    assign seq_pc    = program_counter + PC_STEP;

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            program_counter <= RESET_PC;
            ret_address     <= 32'd0;
        end else begin
            if (jump || branch) begin
                program_counter <= target_pc;
            end else begin
                program_counter <= seq_pc;
            end
            if (jump) begin
                ret_address <= seq_pc;
            end
        end
    end

endmodule

// File: tb/tb_t08_fetch.sv
// tb/tb_t08_fetch.sv - randomized and directed self-checking bench for t08_fetch
module tb_t08_fetch;

    logic        clk;
    logic        nrst;
    logic        jump;
    logic        branch;
    logic [31:0] imm_address;
    logic [31:0] ret_address;
    logic [31:0] program_counter;

    int          n_cmp;
    int          n_err;
    logic        chk_on;
    logic [31:0] m_pc;
    logic [31:0] m_ret;

    t08_fetch dut (
        .clk             (clk),
        .nrst            (nrst),
        .jump            (jump),
        .branch          (branch),
        .imm_address     (imm_address),
        .ret_address     (ret_address),
        .program_counter (program_counter)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state is checked against the DUT on every falling edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_pc", program_counter, m_pc);
            chk("model_ret", ret_address, m_ret);
        end
    end

    task automatic step(input logic j, input logic b, input logic [31:0] imm);
        jump        = j;
        branch      = b;
        imm_address = imm;
        @(posedge clk);
        if (j) m_ret = m_pc + 32'd4;
        if (j || b) m_pc = m_pc + imm;
        else        m_pc = m_pc + 32'd4;
        #1;
    endtask

    // Asserts reset between edges, checks the outputs clear immediately, then releases.
    task automatic do_reset(input string name);
        nrst  = 1'b1;
        m_pc  = 32'd0;
        m_ret = 32'd0;
        #1;
        chk({name, "_pc"}, program_counter, 32'd0);
        chk({name, "_ret"}, ret_address, 32'd0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        chk_on      = 1'b0;
        m_pc        = 32'd0;
        m_ret       = 32'd0;
        nrst        = 1'b1;
        jump        = 1'b0;
        branch      = 1'b0;
        imm_address = 32'd0;
        #2;
        chk("reset_pc", program_counter, 32'd0);
        chk("reset_ret", ret_address, 32'd0);
        chk_on = 1'b1;
        @(posedge clk);
        #1;
        nrst = 1'b0;

        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'd0);
        chk("seq_pc20", program_counter, 32'd20);
        chk("seq_ret0", ret_address, 32'd0);

        step(1'b0, 1'b1, 32'd10);
        chk("branch_pc30", program_counter, 32'd30);
        chk("branch_ret0", ret_address, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        chk("idle_pc34", program_counter, 32'd34);

        step(1'b1, 1'b0, 32'd10);
        chk("jump_pc44", program_counter, 32'd44);
        chk("jump_ret38", ret_address, 32'd38);
        step(1'b0, 1'b0, 32'd0);
        chk("idle_pc48", program_counter, 32'd48);
        chk("idle_ret38", ret_address, 32'd38);

        step(1'b1, 1'b0, 32'd5);
        chk("held_pc53", program_counter, 32'd53);
        chk("held_ret52", ret_address, 32'd52);
        step(1'b1, 1'b0, 32'd5);
        chk("held_pc58", program_counter, 32'd58);
        chk("held_ret57", ret_address, 32'd57);
        step(1'b1, 1'b0, -32'sd10);
        chk("neg_pc48", program_counter, 32'd48);
        chk("neg_ret62", ret_address, 32'd62);

        do_reset("rst_a");
        step(1'b0, 1'b1, 32'd2);
        chk("to_pc2", program_counter, 32'd2);
        step(1'b0, 1'b1, -32'sd10);
        chk("wrap_pc", program_counter, 32'hFFFF_FFF8);

        do_reset("rst_b");
        step(1'b0, 1'b1, 32'd100);
        chk("to_pc100", program_counter, 32'd100);
        step(1'b1, 1'b1, -32'sd4);
        chk("both_pc96", program_counter, 32'd96);
        chk("both_ret104", ret_address, 32'd104);
        do_reset("rst_mid");

        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            logic [31:0] imm;
            r   = $urandom_range(0, 99);
            imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($signed($urandom_range(0, 512)) - 256);
            if (r < 3)       do_reset("rst_rand");
            else if (r < 25) step(1'b1, 1'($urandom_range(0, 1)), imm);
            else if (r < 50) step(1'b0, 1'b1, imm);
            else             step(1'b0, 1'b0, imm);
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
